// File: rtl/mux_arbiter8_sefunmi.sv
// rtl/mux_arbiter8_sefunmi.sv - round-robin owner arbiter for a shared 8-to-1 mux
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req[7:0]    per-requester access request, bit i = requester i
//   done        owner releases the mux (only looked at while granting)
//   grant[7:0]  one-hot owner, zero when nobody owns the mux
//   mux_select  index of the owner, held through release and idle
//   mux_enable  mux enable, high only while granting
//   busy        high while granting and during the release cycle
//   preempt     one-cycle pulse in release when the hold limit forced it
module mux_arbiter8_sefunmi #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic [2:0] mux_select,
    output logic       mux_enable,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Hold counter starts at 0 on the first grant cycle, so reaching
    // MAX_HOLD-1 marks the last allowed cycle.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] mux_select_q, mux_select_d;
    logic       mux_enable_q, mux_enable_d;
    logic       busy_q, busy_d;
    logic       preempt_q, preempt_d;

    logic       found;
    logic [2:0] pick;
    logic [2:0] cand;
    logic       owner_req;
    logic       hold_hit;
    logic       release_now;

    // Round-robin search: ptr+1 first, ptr itself last. 3-bit add wraps 7 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = ptr_q;
        for (int i = 1; i <= 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign owner_req   = req[mux_select_q];
    assign hold_hit    = (hold_q == HOLD_LAST);
    assign release_now = done || !owner_req || hold_hit;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        grant_d      = grant_q;
        mux_select_d = mux_select_q;
        mux_enable_d = mux_enable_q;
        busy_d       = busy_q;
        preempt_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d      = 8'h00;
                mux_enable_d = 1'b0;
                busy_d       = 1'b0;
                if (found) begin
                    state_d      = ST_GRANT;
                    hold_d       = 4'd0;
                    mux_select_d = pick;
                    grant_d      = 8'h01 << pick;
                    mux_enable_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_GRANT: begin
                if (release_now) begin
                    state_d      = ST_RELEASE;
                    ptr_d        = mux_select_q;
                    grant_d      = 8'h00;
                    mux_enable_d = 1'b0;
                    busy_d       = 1'b1;
                    // Only a pure hold-limit exit counts as preemption.
                    preempt_d    = hold_hit && !done && owner_req;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            ST_RELEASE: begin
                state_d      = ST_IDLE;
                grant_d      = 8'h00;
                mux_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                grant_d      = 8'h00;
                mux_enable_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 3'd7;
            hold_q       <= 4'd0;
            grant_q      <= 8'h00;
            mux_select_q <= 3'd0;
            mux_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            preempt_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            hold_q       <= hold_d;
            grant_q      <= grant_d;
            mux_select_q <= mux_select_d;
            mux_enable_q <= mux_enable_d;
            busy_q       <= busy_d;
            preempt_q    <= preempt_d;
        end
    end

    assign grant      = grant_q;
    assign mux_select = mux_select_q;
    assign mux_enable = mux_enable_q;
    assign busy       = busy_q;
    assign preempt    = preempt_q;

endmodule
